// File: rtl/top_rgb_2_gray_pkg.sv
// Shared constants and types for the RGB444-to-grey frame engine.
// Holds the frame geometry, the pixel address width, the FSM state encoding
// (which software also sees through ON_STATE), and the luma weights.
package top_rgb_2_gray_pkg;

  localparam int unsigned IMG_W  = 320;
  localparam int unsigned IMG_H  = 240;
  localparam int unsigned PIX_N  = IMG_W * IMG_H;
  localparam int unsigned ADDR_W = 17;

  // The encoding is software-visible, so the values are pinned.
  typedef enum logic [1:0] {
    ST_LOAD    = 2'b00,
    ST_CONVERT = 2'b01,
    ST_READ    = 2'b10,
    ST_DONE    = 2'b11
  } state_e;

  // Luma weights in 1/256 units; they sum to 256, so full white maps to 255.
  localparam logic [7:0] W_R = 8'd77;
  localparam logic [7:0] W_G = 8'd150;
  localparam logic [7:0] W_B = 8'd29;

endpackage

// File: rtl/rgb444_to_gray.sv
// RGB444 to 8-bit grey converter, one registered stage (1-cycle latency).
// Each 4-bit channel is widened to 8 bits by replication ({c,c} == c*17),
// then grey = (77*R8 + 150*G8 + 29*B8) >> 8 in a 16-bit accumulator.
// Build option: GRAY_ROUND_EN adds 128 before the shift (round to nearest);
// without it the result is truncated.
// Ports:
//   clk_i   clock, rising edge
//   rst_i   synchronous active-high reset, clears the output register
//   rgb_i   pixel {R[11:8], G[7:4], B[3:0]}
//   gray_o  registered grey value
module rgb444_to_gray
  import top_rgb_2_gray_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [11:0] rgb_i,
  output logic [7:0]  gray_o
);

  logic [7:0]  r8, g8, b8;
  logic [15:0] acc;
  logic [7:0]  gray_d, gray_q;

  always_comb begin
    r8  = {rgb_i[11:8], rgb_i[11:8]};
    g8  = {rgb_i[7:4], rgb_i[7:4]};
    b8  = {rgb_i[3:0], rgb_i[3:0]};
    // Weighted sum peaks at 256*255 = 65280, so 16 bits never overflow,
    // even with the rounding constant added.
    acc = 16'(W_R) * 16'(r8) + 16'(W_G) * 16'(g8) + 16'(W_B) * 16'(b8);
`ifdef GRAY_ROUND_EN
    acc = acc + 16'd128;
`else
    acc = acc;
`endif
    gray_d = 8'(acc >> 8);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      gray_q <= '0;
    end else begin
      gray_q <= gray_d;
    end
  end

  assign gray_o = gray_q;

endmodule

// File: rtl/top_rgb_2_gray.sv
// Frame engine: software loads one RGB444 frame into a colour BRAM, the block
// converts every pixel to 8-bit grey into a grey BRAM, software reads it back.
// Build option: GRAY_ROUND_EN (inside rgb444_to_gray) selects rounding.
// Ports:
//   i_CLK                     clock, rising edge
//   i_RSTn                    synchronous active-HIGH reset (legacy name)
//   EN_WRCOLOR_FR_AXI         colour load enable; also restarts from DONE
//   AXI_WRREQUEST_COLOR_BRAM  colour write strobe
//   AXI_ADDR_COLOR_BRAM       colour pixel address
//   AXI_WRDATA_COLOR_BRAM     colour pixel {R,G,B} 4 bits each
//   DONE_WRITE_COLOR_BRAM     sticky: last colour address written
//   AXI_RDREQUEST_GRAY_BRAM   grey read strobe
//   AXI_ADDR_GRAY_BRAM        grey pixel address
//   DATA_FR_GRAY_BRAM         grey read data, 1 cycle after the strobe
//   DONE_WRITE_GRAY_BRAM      sticky: conversion finished
//   DONE_READ_GRAY_BRAM       sticky: last grey address read
//   ON_STATE                  FSM state, 00 LOAD 01 CONVERT 10 READ 11 DONE
module top_rgb_2_gray
  import top_rgb_2_gray_pkg::*;
#(
  parameter int unsigned ImgW = IMG_W,
  parameter int unsigned ImgH = IMG_H
) (
  input  logic              i_CLK,
  input  logic              i_RSTn,
  input  logic              EN_WRCOLOR_FR_AXI,
  input  logic              AXI_WRREQUEST_COLOR_BRAM,
  input  logic [ADDR_W-1:0] AXI_ADDR_COLOR_BRAM,
  input  logic [11:0]       AXI_WRDATA_COLOR_BRAM,
  output logic              DONE_WRITE_COLOR_BRAM,
  input  logic              AXI_RDREQUEST_GRAY_BRAM,
  input  logic [ADDR_W-1:0] AXI_ADDR_GRAY_BRAM,
  output logic [7:0]        DATA_FR_GRAY_BRAM,
  output logic              DONE_WRITE_GRAY_BRAM,
  output logic              DONE_READ_GRAY_BRAM,
  output logic [1:0]        ON_STATE
);

  localparam int unsigned       PixN     = ImgW * ImgH;
  localparam int unsigned       MemAw    = $clog2(PixN);
  localparam logic [ADDR_W-1:0] PixNA    = ADDR_W'(PixN);
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(PixN - 1);

  state_e            state_q, state_d;
  logic              done_wc_q, done_wc_d;
  logic              done_wg_q, done_wg_d;
  logic              done_rg_q, done_rg_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              v1_q, v2_q;
  logic [ADDR_W-1:0] a1_q, a2_q;
  logic [11:0]       color_rd_q;
  logic [7:0]        data_q;
  logic [7:0]        gray_w;
  logic              color_we, issue, gray_we, gray_re;

  logic [11:0] color_mem [PixN];
  logic [7:0]  gray_mem  [PixN];

  always_comb begin
    color_we = (state_q == ST_LOAD) && EN_WRCOLOR_FR_AXI && AXI_WRREQUEST_COLOR_BRAM &&
               (AXI_ADDR_COLOR_BRAM < PixNA);
    issue    = (state_q == ST_CONVERT) && (cnt_q < PixNA);
    gray_we  = (state_q == ST_CONVERT) && v2_q;
    gray_re  = (state_q == ST_READ) && AXI_RDREQUEST_GRAY_BRAM && (AXI_ADDR_GRAY_BRAM < PixNA);
  end

  always_comb begin
    state_d   = state_q;
    done_wc_d = done_wc_q;
    done_wg_d = done_wg_q;
    done_rg_d = done_rg_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      ST_LOAD: begin
        cnt_d = '0;
        if (color_we && (AXI_ADDR_COLOR_BRAM == LastAddr)) begin
          done_wc_d = 1'b1;
          state_d   = ST_CONVERT;
        end
      end
      ST_CONVERT: begin
        // Counter stops at PixN so the issue stage idles while the pipe drains.
        if (issue) cnt_d = cnt_q + 1'b1;
        if (gray_we && (a2_q == LastAddr)) begin
          done_wg_d = 1'b1;
          state_d   = ST_READ;
          cnt_d     = '0;
        end
      end
      ST_READ: begin
        if (gray_re && (AXI_ADDR_GRAY_BRAM == LastAddr)) begin
          done_rg_d = 1'b1;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        if (EN_WRCOLOR_FR_AXI) begin
          done_wc_d = 1'b0;
          done_wg_d = 1'b0;
          done_rg_d = 1'b0;
          state_d   = ST_LOAD;
        end
      end
    endcase
  end

  always_ff @(posedge i_CLK) begin
    if (i_RSTn) begin
      state_q   <= ST_LOAD;
      done_wc_q <= 1'b0;
      done_wg_q <= 1'b0;
      done_rg_q <= 1'b0;
      cnt_q     <= '0;
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      a1_q      <= '0;
      a2_q      <= '0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      done_wc_q <= done_wc_d;
      done_wg_q <= done_wg_d;
      done_rg_q <= done_rg_d;
      cnt_q     <= cnt_d;
      // Stage 1 tracks the BRAM read, stage 2 tracks the converter register.
      v1_q      <= issue;
      a1_q      <= cnt_q;
      v2_q      <= v1_q;
      a2_q      <= a1_q;
      if (gray_re) data_q <= gray_mem[MemAw'(AXI_ADDR_GRAY_BRAM)];
    end
  end

  // BRAM ports, not reset. Addresses are range-checked before truncation.
  always_ff @(posedge i_CLK) begin
    if (color_we) color_mem[MemAw'(AXI_ADDR_COLOR_BRAM)] <= AXI_WRDATA_COLOR_BRAM;
    if (issue)    color_rd_q <= color_mem[MemAw'(cnt_q)];
    if (gray_we)  gray_mem[MemAw'(a2_q)] <= gray_w;
  end

  rgb444_to_gray u_conv (
    .clk_i  (i_CLK),
    .rst_i  (i_RSTn),
    .rgb_i  (color_rd_q),
    .gray_o (gray_w)
  );

  assign DONE_WRITE_COLOR_BRAM = done_wc_q;
  assign DONE_WRITE_GRAY_BRAM  = done_wg_q;
  assign DONE_READ_GRAY_BRAM   = done_rg_q;
  assign DATA_FR_GRAY_BRAM     = data_q;
  assign ON_STATE              = state_q;

endmodule

// File: tb/tb_top_rgb_2_gray.sv
// Directed bench for top_rgb_2_gray on a reduced 16x8 frame (same control
// flow as 320x240, far fewer cycles).
module tb_top_rgb_2_gray;

  localparam int unsigned W    = 16;
  localparam int unsigned H    = 8;
  localparam int unsigned N    = W * H;
  localparam logic [16:0] LAST = 17'(N - 1);

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0, wr = 1'b0, rd = 1'b0;
  logic [16:0] waddr = '0, raddr = '0;
  logic [11:0] wdata = '0;
  logic        done_wc, done_wg, done_rg;
  logic [7:0]  rdata;
  logic [1:0]  st;

  int n_chk = 0;
  int n_err = 0;
  int cyc;

  always #5 clk = ~clk;

  top_rgb_2_gray #(
    .ImgW (W),
    .ImgH (H)
  ) dut (
    .i_CLK                    (clk),
    .i_RSTn                   (rst),
    .EN_WRCOLOR_FR_AXI        (en),
    .AXI_WRREQUEST_COLOR_BRAM (wr),
    .AXI_ADDR_COLOR_BRAM      (waddr),
    .AXI_WRDATA_COLOR_BRAM    (wdata),
    .DONE_WRITE_COLOR_BRAM    (done_wc),
    .AXI_RDREQUEST_GRAY_BRAM  (rd),
    .AXI_ADDR_GRAY_BRAM       (raddr),
    .DATA_FR_GRAY_BRAM        (rdata),
    .DONE_WRITE_GRAY_BRAM     (done_wg),
    .DONE_READ_GRAY_BRAM      (done_rg),
    .ON_STATE                 (st)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference luma: channel*17, integer weights, optional +128, >>8.
  function automatic logic [7:0] gray_ref(input logic [11:0] p);
    int unsigned acc;
    acc = 77 * (int'(p[11:8]) * 17) + 150 * (int'(p[7:4]) * 17) + 29 * (int'(p[3:0]) * 17);
`ifdef GRAY_ROUND_EN
    acc = acc + 128;
`endif
    return 8'(acc >> 8);
  endfunction

  function automatic logic [11:0] pat(input int i);
    return 12'(12'h111 + 8 * i);
  endfunction

  // Advance one rising edge; outputs are then sampled 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_px(input logic [16:0] a, input logic [11:0] d);
    wr = 1'b1; waddr = a; wdata = d;
    step();
    wr = 1'b0;
  endtask

  task automatic read_px(input logic [16:0] a);
    rd = 1'b1; raddr = a;
    step();
    rd = 1'b0;
  endtask

  // Counts edges until leaving CONVERT, bounded.
  task automatic wait_convert(output int n);
    n = 0;
    while (st == 2'b01 && n < 4 * N) begin
      step();
      n++;
    end
  endtask

  logic [7:0] exp_f00, exp_00f;

  initial begin
`ifdef GRAY_ROUND_EN
    exp_f00 = 8'h4D; exp_00f = 8'h1D;
`else
    exp_f00 = 8'h4C; exp_00f = 8'h1C;
`endif
    #13 rst = 1'b1;
    #15 rst = 1'b0;
    #1;
    check_eq("rst_state", st, 2'b00);
    check_eq("rst_done_wc", done_wc, 1'b0);
    check_eq("rst_done_wg", done_wg, 1'b0);
    check_eq("rst_done_rg", done_rg, 1'b0);
    check_eq("rst_data", rdata, 8'h00);

    // 1: full frame load
    en = 1'b1;
    for (int i = 0; i < N; i++) begin
      write_px(17'(i), pat(i));
      if (i == N - 2) begin
        check_eq("load_state_before_last", st, 2'b00);
        check_eq("load_done_before_last", done_wc, 1'b0);
      end
    end
    check_eq("load_done_wc", done_wc, 1'b1);
    check_eq("load_to_convert", st, 2'b01);
    en = 1'b0;

    // 2: conversion length, reads ignored meanwhile
    rd = 1'b1; raddr = '0;
    wait_convert(cyc);
    rd = 1'b0;
    check_eq("convert_cycles", cyc, N + 2);
    check_eq("convert_to_read", st, 2'b10);
    check_eq("convert_done_wg", done_wg, 1'b1);
    check_eq("convert_read_ignored", rdata, 8'h00);

    // 3: read back every pixel
    for (int i = 0; i < N; i++) begin
      if (i == N - 1) begin
        check_eq("read_state_before_last", st, 2'b10);
        check_eq("read_done_before_last", done_rg, 1'b0);
      end
      read_px(17'(i));
      if (i == 0) check_eq("read_addr0", rdata, 8'h11);
      check_eq($sformatf("read_px%0d", i), rdata, gray_ref(pat(i)));
    end
    check_eq("read_done_rg", done_rg, 1'b1);
    check_eq("read_to_done", st, 2'b11);
    step(); step();
    check_eq("done_data_hold", rdata, gray_ref(pat(N - 1)));
    check_eq("done_state_hold", st, 2'b11);

    // 4: corner colours
    en = 1'b1;
    step();
    check_eq("restart_state", st, 2'b00);
    check_eq("restart_done_wc", done_wc, 1'b0);
    check_eq("restart_done_wg", done_wg, 1'b0);
    check_eq("restart_done_rg", done_rg, 1'b0);
    write_px(17'd0, 12'hF00);
    write_px(17'd1, 12'h0F0);
    write_px(17'd2, 12'h00F);
    write_px(17'd3, 12'hFFF);
    write_px(17'd4, 12'h111);
    write_px(LAST, 12'h000);
    en = 1'b0;
    wait_convert(cyc);
    check_eq("corner_convert_cycles", cyc, N + 2);
    read_px(17'd0); check_eq("gray_F00", rdata, exp_f00);
    read_px(17'd1); check_eq("gray_0F0", rdata, 8'h95);
    read_px(17'd2); check_eq("gray_00F", rdata, exp_00f);
    read_px(17'd3); check_eq("gray_FFF", rdata, 8'hFF);
    read_px(17'd4); check_eq("gray_111", rdata, 8'h11);
    read_px(17'd80000); check_eq("read_oob_hold", rdata, 8'h11);
    read_px(LAST);
    check_eq("corner_done", st, 2'b11);

    // 5: ignored writes
    en = 1'b1;
    step();
    en = 1'b0;
    write_px(17'd0, 12'hFFF);
    check_eq("en0_state", st, 2'b00);
    en = 1'b1;
    write_px(17'd80000, 12'hFFF);
    check_eq("oob_state", st, 2'b00);
    check_eq("oob_done_wc", done_wc, 1'b0);
    write_px(17'(N), 12'hFFF);
    check_eq("pixn_state", st, 2'b00);
    write_px(LAST, 12'h000);
    en = 1'b0;
    wait_convert(cyc);
    check_eq("ign_convert_cycles", cyc, N + 2);
    read_px(17'd0); check_eq("ign_px0_unchanged", rdata, exp_f00);
    read_px(17'd1); check_eq("ign_px1_unchanged", rdata, 8'h95);
    read_px(LAST);
    check_eq("ign_done", st, 2'b11);

    // 6: reset during CONVERT
    en = 1'b1;
    step();
    write_px(LAST, 12'h000);
    en = 1'b0;
    for (int i = 0; i < 10; i++) step();
    check_eq("mid_convert_state", st, 2'b01);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("midrst_state", st, 2'b00);
    check_eq("midrst_done_wc", done_wc, 1'b0);
    check_eq("midrst_done_wg", done_wg, 1'b0);
    check_eq("midrst_done_rg", done_rg, 1'b0);
    check_eq("midrst_data", rdata, 8'h00);
    step(); step();
    check_eq("midrst_stays_load", st, 2'b00);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
